// File: rtl/segment_transition_ctl_pkg.sv
// Shared definitions for the segment transition controller: transition modes,
// FSM encoding and the default segment count.
package segment_transition_ctl_pkg;

    // Default segment count for new instances; the next generation raises this to 4.
    localparam int NumSegmentDefault = 2;

    typedef enum logic [7:0] {
        MODE_SYNC_IDX = 8'h00,
        MODE_SYS_TIME = 8'h01,
        MODE_GPIO     = 8'h02,
        MODE_EXT      = 8'hF0
    } transition_mode_t;

    typedef enum logic [1:0] {
        SEG_STATE_RUN       = 2'd0,
        SEG_STATE_WAIT_TRIG = 2'd1,
        SEG_STATE_STOPPED   = 2'd2
    } seg_state_t;

    function automatic logic is_valid_mode(input logic [7:0] code);
        case (code)
            MODE_SYNC_IDX, MODE_SYS_TIME, MODE_GPIO, MODE_EXT: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gpio_edge_sync.sv
// Two-flop synchroniser plus registered rising-edge detector for GPIO triggers.
// Edges are suppressed until the pipeline holds real samples after reset.
module gpio_edge_sync #(
    parameter int Width = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] rise
);

    logic [Width-1:0] sync1;
    logic [Width-1:0] sync2;
    logic [Width-1:0] prev;
    logic [2:0]       fill;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which is what makes a shift chain work.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            fill  <= '0;
            rise  <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
            fill  <= {fill[1:0], 1'b1};
            // A level already high when the pipeline fills is not an edge.
            rise  <= fill[2] ? (sync2 & ~prev) : '0;
        end
    end

endmodule

// File: rtl/segment_transition_ctl.sv
// Segment swap controller: latches a segment-change request, waits for its
// trigger, switches the active segment and counts loop repetitions.
module segment_transition_ctl
    import segment_transition_ctl_pkg::*;
#(
    parameter int  NumSegment   = NumSegmentDefault,
    parameter int  RepWidth     = 16,
    parameter int  SysTimeWidth = 64,
    parameter int  NumGpio      = 4,
    localparam int SegW         = (NumSegment > 1) ? $clog2(NumSegment) : 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    UPDATE,
    input  logic [SegW-1:0]         REQ_SEGMENT,
    input  logic [RepWidth-1:0]     REP,
    input  logic [7:0]              TRANSITION_MODE,
    input  logic [SysTimeWidth-1:0] TRANSITION_VALUE,
    input  logic [SysTimeWidth-1:0] SYS_TIME,
    input  logic [NumGpio-1:0]      GPIO_IN,
    input  logic                    CYCLE_END,
    output logic [SegW-1:0]         SEGMENT,
    output logic                    START,
    output logic                    STOP,
    output logic                    WAITING,
    output logic                    ERR
);

    localparam int GIdxW = (NumGpio > 1) ? $clog2(NumGpio) : 1;
    localparam logic [RepWidth-1:0] RepInf   = '1;
    localparam logic [RepWidth-1:0] RepSat   = {{(RepWidth-1){1'b1}}, 1'b0};
    localparam logic [SegW:0]       SegCount = (SegW+1)'(NumSegment);
    localparam logic [SegW-1:0]     SegLast  = SegW'(NumSegment - 1);

    seg_state_t              state_q, state_d;
    logic [SegW-1:0]         seg_q, seg_d;
    logic [RepWidth-1:0]     rep_cnt_q, rep_cnt_d;
    logic [RepWidth-1:0]     act_rep_q, act_rep_d;
    logic                    act_ext_q, act_ext_d;
    logic [SegW-1:0]         pend_seg_q, pend_seg_d;
    logic [RepWidth-1:0]     pend_rep_q, pend_rep_d;
    transition_mode_t        pend_mode_q, pend_mode_d;
    logic [SysTimeWidth-1:0] pend_value_q, pend_value_d;
    logic                    start_q, start_d;
    logic                    stop_q, stop_d;
    logic                    waiting_q, waiting_d;
    logic                    err_q, err_d;

    logic [NumGpio-1:0] gpio_rise;
    logic [GIdxW-1:0]   gpio_sel;
    logic               req_ok;
    logic               trigger;
    logic               switch_now;
    logic               count_en;
    logic               limit_hit;

    gpio_edge_sync #(.Width(NumGpio)) u_gpio_edge_sync (
        .CLK  (CLK),
        .RST_N(RST_N),
        .din  (GPIO_IN),
        .rise (gpio_rise)
    );

    assign gpio_sel = pend_value_q[GIdxW-1:0];
    assign req_ok   = UPDATE && ({1'b0, REQ_SEGMENT} < SegCount)
                      && is_valid_mode(TRANSITION_MODE);

    // NOTE: every signal written in a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        trigger = 1'b0;
        case (pend_mode_q)
            // A stopped old segment produces no CYCLE_END, so fire right away.
            MODE_SYNC_IDX: trigger = CYCLE_END || stop_q;
            MODE_SYS_TIME: trigger = (SYS_TIME >= pend_value_q);
            MODE_GPIO:     trigger = gpio_rise[gpio_sel];
            MODE_EXT:      trigger = 1'b1;
            default:       trigger = 1'b0;
        endcase
    end

    assign switch_now = (state_q == SEG_STATE_WAIT_TRIG) && trigger && !req_ok;
    assign count_en   = CYCLE_END && (state_q != SEG_STATE_STOPPED) && !stop_q;
    assign limit_hit  = (act_rep_q != RepInf) && (rep_cnt_q == act_rep_q);

    always_comb begin
        state_d      = state_q;
        seg_d        = seg_q;
        rep_cnt_d    = rep_cnt_q;
        act_rep_d    = act_rep_q;
        act_ext_d    = act_ext_q;
        pend_seg_d   = pend_seg_q;
        pend_rep_d   = pend_rep_q;
        pend_mode_d  = pend_mode_q;
        pend_value_d = pend_value_q;
        start_d      = 1'b0;
        stop_d       = stop_q;
        waiting_d    = waiting_q;
        err_d        = UPDATE && !req_ok;

        if (switch_now) begin
            seg_d     = pend_seg_q;
            start_d   = 1'b1;
            rep_cnt_d = '0;
            stop_d    = 1'b0;
            waiting_d = 1'b0;
            act_rep_d = pend_rep_q;
            act_ext_d = (pend_mode_q == MODE_EXT);
            state_d   = SEG_STATE_RUN;
        end else if (count_en) begin
            if (limit_hit) begin
                if (act_ext_q && (state_q == SEG_STATE_RUN)) begin
                    seg_d     = (seg_q == SegLast) ? '0 : seg_q + 1'b1;
                    start_d   = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    stop_d = 1'b1;
                    if (state_q == SEG_STATE_RUN) begin
                        state_d = SEG_STATE_STOPPED;
                    end
                end
            end else if (rep_cnt_q != RepSat) begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end

        // A valid request always wins over the old request's trigger.
        if (req_ok) begin
            pend_seg_d   = REQ_SEGMENT;
            pend_rep_d   = REP;
            pend_mode_d  = transition_mode_t'(TRANSITION_MODE);
            pend_value_d = TRANSITION_VALUE;
            waiting_d    = 1'b1;
            state_d      = SEG_STATE_WAIT_TRIG;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= SEG_STATE_RUN;
            seg_q        <= '0;
            rep_cnt_q    <= '0;
            act_rep_q    <= RepInf;
            act_ext_q    <= 1'b0;
            pend_seg_q   <= '0;
            pend_rep_q   <= '0;
            pend_mode_q  <= MODE_SYNC_IDX;
            pend_value_q <= '0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            waiting_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            seg_q        <= seg_d;
            rep_cnt_q    <= rep_cnt_d;
            act_rep_q    <= act_rep_d;
            act_ext_q    <= act_ext_d;
            pend_seg_q   <= pend_seg_d;
            pend_rep_q   <= pend_rep_d;
            pend_mode_q  <= pend_mode_d;
            pend_value_q <= pend_value_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            waiting_q    <= waiting_d;
            err_q        <= err_d;
        end
    end

    assign SEGMENT = seg_q;
    assign START   = start_q;
    assign STOP    = stop_q;
    assign WAITING = waiting_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Directed bench for segment_transition_ctl: a 4-segment instance carries the
// main scenarios, a 3-segment instance checks out-of-range segment rejection.
module tb_segment_transition_ctl;

    localparam logic [7:0] M_SYNC = 8'h00;
    localparam logic [7:0] M_TIME = 8'h01;
    localparam logic [7:0] M_GPIO = 8'h02;
    localparam logic [7:0] M_EXT  = 8'hF0;
    localparam logic [7:0] M_BAD  = 8'h07;
    localparam logic [15:0] REP_INF = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        update = 1'b0;
    logic [1:0]  req_segment = '0;
    logic [15:0] rep = '0;
    logic [7:0]  transition_mode = '0;
    logic [63:0] transition_value = '0;
    logic [63:0] sys_time = '0;
    logic [3:0]  gpio_in = '0;
    logic        cycle_end = 1'b0;

    logic [1:0] segment;
    logic       start, stop, waiting, err;
    logic [1:0] segment_b;
    logic       start_b, stop_b, waiting_b, err_b;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cnt = 0;

    always #5 clk = ~clk;

    segment_transition_ctl #(.NumSegment(4), .RepWidth(16), .SysTimeWidth(64), .NumGpio(4)) dut (
        .CLK(clk), .RST_N(rst_n), .UPDATE(update), .REQ_SEGMENT(req_segment), .REP(rep),
        .TRANSITION_MODE(transition_mode), .TRANSITION_VALUE(transition_value),
        .SYS_TIME(sys_time), .GPIO_IN(gpio_in), .CYCLE_END(cycle_end),
        .SEGMENT(segment), .START(start), .STOP(stop), .WAITING(waiting), .ERR(err)
    );

    segment_transition_ctl #(.NumSegment(3), .RepWidth(16), .SysTimeWidth(64), .NumGpio(4)) dut_b (
        .CLK(clk), .RST_N(rst_n), .UPDATE(update), .REQ_SEGMENT(req_segment), .REP(rep),
        .TRANSITION_MODE(transition_mode), .TRANSITION_VALUE(transition_value),
        .SYS_TIME(sys_time), .GPIO_IN(gpio_in), .CYCLE_END(cycle_end),
        .SEGMENT(segment_b), .START(start_b), .STOP(stop_b), .WAITING(waiting_b), .ERR(err_b)
    );

    always @(negedge clk) if (start) start_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_update(input logic [1:0] seg, input logic [15:0] r,
                               input logic [7:0] mode, input logic [63:0] val);
        update = 1'b1;
        req_segment = seg;
        rep = r;
        transition_mode = mode;
        transition_value = val;
        step();
        update = 1'b0;
    endtask

    task automatic pulse_cycle_end();
        cycle_end = 1'b1;
        step();
        cycle_end = 1'b0;
    endtask

    initial begin
        int seen;
        int hit;
        int lat;
        logic [1:0] ext_seq [4];
        ext_seq[0] = 2'd3; ext_seq[1] = 2'd0; ext_seq[2] = 2'd1; ext_seq[3] = 2'd2;

        // Reset state and infinite repetition on segment 0
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        check("rst_segment", segment, 0);
        check("rst_start", start, 0);
        check("rst_stop", stop, 0);
        check("rst_waiting", waiting, 0);
        check("rst_err", err, 0);
        for (int i = 0; i < 3; i++) begin
            pulse_cycle_end();
            step();
        end
        check("inf_segment", segment, 0);
        check("inf_stop", stop, 0);
        check("inf_no_start", start_cnt, 0);

        // Segment 3 is valid for 4 segments, out of range for 3
        send_update(2'd3, 16'd0, M_SYNC, 64'd0);
        check("seg3_a_waiting", waiting, 1);
        check("seg3_a_err", err, 0);
        check("seg3_b_err", err_b, 1);
        check("seg3_b_waiting", waiting_b, 0);
        check("seg3_b_segment", segment_b, 0);
        step();
        check("seg3_b_err_pulse", err_b, 0);

        // Replace pending request: SYNC_IDX seg 1, REP 1
        send_update(2'd1, 16'd1, M_SYNC, 64'd0);
        check("sync_waiting", waiting, 1);
        step(); step();
        check("sync_hold_seg", segment, 0);
        check("sync_hold_start", start_cnt, 0);
        pulse_cycle_end();
        check("sync_segment", segment, 1);
        check("sync_start", start, 1);
        check("sync_waiting_clr", waiting, 0);
        step();
        check("sync_start_pulse", start, 0);
        pulse_cycle_end();
        check("rep1_stop_early", stop, 0);
        pulse_cycle_end();
        check("rep1_stop", stop, 1);
        pulse_cycle_end();
        check("stopped_hold_seg", segment, 1);
        check("stopped_start_cnt", start_cnt, 1);

        // SYS_TIME target in the future
        sys_time = 64'd990;
        send_update(2'd2, REP_INF, M_TIME, 64'd1000);
        check("time_waiting", waiting, 1);
        check("time_stop_held", stop, 1);
        hit = 0;
        for (int v = 991; v <= 1010; v++) begin
            sys_time = 64'(v);
            step();
            if (start && hit == 0) hit = v;
        end
        check("time_hit_value", hit, 1000);
        check("time_segment", segment, 2);
        check("time_stop_clr", stop, 0);

        // SYS_TIME target already past: switch at t+2
        send_update(2'd3, REP_INF, M_TIME, 64'd500);
        check("past_t1_start", start, 0);
        check("past_t1_seg", segment, 2);
        step();
        check("past_t2_start", start, 1);
        check("past_t2_seg", segment, 3);

        // EXT mode auto-advance
        send_update(2'd2, 16'd0, M_EXT, 64'd0);
        check("ext_t1_waiting", waiting, 1);
        step();
        check("ext_t2_seg", segment, 2);
        check("ext_t2_start", start, 1);
        step();
        for (int i = 0; i < 4; i++) begin
            pulse_cycle_end();
            check($sformatf("ext_seg_%0d", i), segment, ext_seq[i]);
            check($sformatf("ext_start_%0d", i), start, 1);
            step();
            check($sformatf("ext_start_low_%0d", i), start, 0);
        end
        check("ext_stop", stop, 0);

        // GPIO trigger on input 2; input 1 must be ignored
        send_update(2'd1, REP_INF, M_GPIO, 64'd2);
        seen = start_cnt;
        gpio_in = 4'b0010;
        step(); step();
        gpio_in = 4'b0000;
        for (int i = 0; i < 8; i++) step();
        check("gpio_wrong_pin_start", start_cnt, seen);
        check("gpio_wrong_pin_waiting", waiting, 1);
        gpio_in = 4'b0100;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            step();
            if (start) lat = i;
        end
        check("gpio_latency_in_range", (lat >= 3 && lat <= 4), 1);
        check("gpio_segment", segment, 1);
        gpio_in = 4'b0000;
        step();

        // Bad mode rejected in RUN, then in WAIT_TRIG with pending kept
        send_update(2'd0, 16'd0, M_BAD, 64'd0);
        check("badmode_err", err, 1);
        check("badmode_waiting", waiting, 0);
        check("badmode_segment", segment, 1);
        send_update(2'd0, REP_INF, M_SYNC, 64'd0);
        check("pend_waiting", waiting, 1);
        send_update(2'd2, REP_INF, M_BAD, 64'd0);
        check("pend_badmode_err", err, 1);
        check("pend_badmode_waiting", waiting, 1);
        pulse_cycle_end();
        check("pend_kept_segment", segment, 0);
        check("pend_kept_err_clr", err, 0);

        // UPDATE together with the old request's trigger
        send_update(2'd2, REP_INF, M_SYNC, 64'd0);
        cycle_end = 1'b1;
        send_update(2'd3, REP_INF, M_SYNC, 64'd0);
        cycle_end = 1'b0;
        check("race_no_start", start, 0);
        check("race_segment", segment, 0);
        check("race_waiting", waiting, 1);
        pulse_cycle_end();
        check("race_new_segment", segment, 3);

        // Reset while waiting drops the pending request
        send_update(2'd1, REP_INF, M_TIME, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rstwait_waiting_pre", waiting, 1);
        rst_n = 1'b0;
        gpio_in = 4'b0100;
        step();
        check("rstwait_waiting", waiting, 0);
        check("rstwait_segment", segment, 0);
        rst_n = 1'b1;

        // Input already high after reset is not an edge
        send_update(2'd1, REP_INF, M_GPIO, 64'd2);
        seen = start_cnt;
        for (int i = 0; i < 8; i++) step();
        check("gpio_high_after_rst_start", start_cnt, seen);
        check("gpio_high_after_rst_seg", segment, 0);
        gpio_in = 4'b0000;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
